genius_seq_ctrl: RTL and testbench
==================================

GENIUS_SEQ_CTRL -- requirements
Module: genius_seq_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 25_000_000, meaning cycles each sequence step is lit.
REQ-002 SHALL have parameter GAP_CYCLES, default 12_500_000, meaning dark cycles between steps and before each round.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250_000_000, meaning max cycles waiting for a press (used only under REQ-030).
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit; level sampled in IDLE/WIN/FAIL to begin a new game.
REQ-007 SHALL have port btn, input, 4 bits; player buttons, one bit per colour, already synchronised and debounced.
REQ-008 SHALL have port rom_data, input, 4 bits; one-hot colour from the sequence ROM for rom_addr, combinational.
REQ-009 SHALL have port rom_addr, output, 4 bits; step index driven to the sequence ROM.
REQ-010 SHALL have port leds, output, 4 bits; colour lamps.
REQ-011 SHALL have port round, output, 5 bits; current round length, 1..16.
REQ-012 SHALL have ports busy, win and fail, output, 1 bit each; game in progress, game won, game lost.

Function
REQ-013 SHALL implement states IDLE, GAP, SHOW, INPUT, RELEASE, WIN and FAIL.
REQ-014 IDLE/WIN/FAIL with start=1 SHALL go to GAP with round=1, step=0 on the next edge.
REQ-015 GAP SHALL hold leds=0 for exactly GAP_CYCLES, then go to SHOW.
REQ-016 SHOW SHALL drive rom_addr=step and leds=rom_data for exactly SHOW_CYCLES.
REQ-017 At the end of SHOW, step<round-1: step+1, GAP; step=round-1: step=0, INPUT.
REQ-018 INPUT SHALL wait for btn to change from 0 to nonzero; btn nonzero on entry SHALL be ignored until it returns to 0.
REQ-019 On a press, rom_addr=step; btn==rom_data (exact one-hot match) is correct; else FAIL next cycle, even if multi-hot.
REQ-020 A correct press SHALL go to RELEASE; leds=btn during INPUT and RELEASE.
REQ-021 RELEASE SHALL wait for btn==0; then, step<round-1: step+1, INPUT; step=round-1 and round<16: round+1, step=0, GAP; round=16: WIN.
REQ-022 WIN SHALL drive leds=4'b1111 and win=1; FAIL SHALL drive leds=4'b0000 and fail=1; both hold until start.
REQ-023 busy SHALL be 1 in GAP, SHOW, INPUT and RELEASE, else 0; start while busy SHALL be ignored.
REQ-024 rom_addr SHALL equal step in every state; step and round SHALL never leave the ranges 0..15 and 1..16.
REQ-025 The timer SHALL reload on every state entry; a 1-cycle parameter value SHALL give exactly one cycle in the state.

Reset
REQ-026 rst_n=0 SHALL force IDLE immediately, from any state including mid-SHOW or mid-RELEASE.
REQ-027 Reset values SHALL be: rom_addr=0, leds=0, round=1, busy=0, win=0, fail=0, step=0, timer=0.
REQ-028 Outputs SHALL be registered or decoded from registered state only, with no path from btn/start to busy/win/fail.

Configuration
REQ-029 Macro GENIUS_TIMEOUT_EN SHALL select the input timeout feature.
REQ-030 With GENIUS_TIMEOUT_EN defined, INPUT held TIMEOUT_CYCLES with no press SHALL go to FAIL; the timer restarts on INPUT entry.
REQ-031 Without GENIUS_TIMEOUT_EN, INPUT SHALL wait indefinitely and the timeout logic SHALL not exist.

Structure
REQ-032 A shared package genius_pkg SHALL hold the state enum, COLOR_W=4, STEP_W=4, MAX_ROUND=16.
REQ-033 Down-counter genius_timer (load value, load, done) SHALL be the one sub-module, shared by GAP, SHOW and timeout.
REQ-034 The sequence ROM SHALL be external, connected via rom_addr/rom_data.

Verification (bench: decSeq11 as ROM, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20)
REQ-035 start pulse -> GAP 2 cycles, SHOW 4 cycles with leds=0001, INPUT; busy=1, round=1.
REQ-036 Round 1 press 0001 then release -> GAP, round=2; SHOW leds 0001 then 1000.
REQ-037 Round 2 press 0001, release, press 0100 (expected 1000) -> fail=1, leds=0000, busy=0.
REQ-038 Correct presses through round 16 (0001,1000,0100,...,0010) -> win=1, leds=1111; start -> round=1.
REQ-039 rst_n low during SHOW of round 3 -> same-cycle IDLE, all outputs at REQ-027 values.
REQ-040 GENIUS_TIMEOUT_EN defined, no press for 20 cycles in INPUT -> fail=1; undefined -> still INPUT after 1000 cycles.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and constants for the genius sequence game controller.
package genius_pkg;

    localparam int COLOR_W   = 4;
    localparam int STEP_W    = 4;
    localparam int ROUND_W   = 5;
    localparam int MAX_ROUND = 16;
    localparam int TIMER_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_SHOW,
        ST_INPUT,
        ST_RELEASE,
        ST_WIN,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/genius_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module genius_timer
    import genius_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/genius_seq_ctrl.sv
// Memory-game sequencer: shows a growing colour sequence, then checks player presses.
// Define GENIUS_TIMEOUT_EN to fail a round when no press arrives within TIMEOUT_CYCLES.
module genius_seq_ctrl
    import genius_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES    = 25_000_000,
    parameter int unsigned GAP_CYCLES     = 12_500_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COLOR_W-1:0] btn,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [STEP_W-1:0]  rom_addr,
    output logic [COLOR_W-1:0] leds,
    output logic [ROUND_W-1:0] round,
    output logic               busy,
    output logic               win,
    output logic               fail,
    output state_t             state_o
);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic                armed_q, armed_d;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_load_val;
    logic                timer_done;
    logic                last_step;
    logic                btn_idle;
    logic                press;

    genius_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .done_o     (timer_done)
    );

    assign last_step = ({1'b0, step_q} == (round_q - ROUND_W'(1)));
    assign btn_idle  = (btn == '0);
    // A press only counts once the buttons have been seen idle inside INPUT.
    assign press     = (state_q == ST_INPUT) && armed_q && !btn_idle;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE, ST_WIN, ST_FAIL: begin
                if (start) begin
                    state_d = ST_GAP;
                    step_d  = '0;
                    round_d = ROUND_W'(1);
                end
            end
            ST_GAP: begin
                if (timer_done) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (timer_done) begin
                    if (last_step) begin
                        step_d  = '0;
                        state_d = ST_INPUT;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_INPUT: begin
                if (press) begin
                    state_d = (btn == rom_data) ? ST_RELEASE : ST_FAIL;
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (timer_done) begin
                    state_d = ST_FAIL;
                end
`endif
            end
            ST_RELEASE: begin
                if (btn_idle) begin
                    if (!last_step) begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = ST_INPUT;
                    end else if (round_q == ROUND_W'(MAX_ROUND)) begin
                        state_d = ST_WIN;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                        step_d  = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every state change reloads the timer with the duration of the state being entered.
    always_comb begin
        timer_load     = (state_d != state_q);
        timer_load_val = '0;
        case (state_d)
            ST_GAP:   timer_load_val = TIMER_W'(GAP_CYCLES - 1);
            ST_SHOW:  timer_load_val = TIMER_W'(SHOW_CYCLES - 1);
            ST_INPUT: timer_load_val = TIMER_W'(TIMEOUT_CYCLES - 1);
            default:  timer_load_val = '0;
        endcase
    end

    assign armed_d = (state_d == ST_INPUT) &&
                     (btn_idle || ((state_q == ST_INPUT) && armed_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            round_q <= ROUND_W'(1);
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            round_q <= round_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        leds = '0;
        case (state_q)
            ST_SHOW:             leds = rom_data;
            ST_INPUT, ST_RELEASE: leds = btn;
            ST_WIN:              leds = '1;
            default:             leds = '0;
        endcase
    end

    assign rom_addr = step_q;
    assign round    = round_q;
    assign busy     = (state_q == ST_GAP) || (state_q == ST_SHOW) ||
                      (state_q == ST_INPUT) || (state_q == ST_RELEASE);
    assign win      = (state_q == ST_WIN);
    assign fail     = (state_q == ST_FAIL);
    assign state_o  = state_q;

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// Directed bench for genius_seq_ctrl with a 16-entry sequence ROM model.
module tb_genius_seq_ctrl;
    import genius_pkg::*;

    localparam int SHOW_C = 4;
    localparam int GAP_C  = 2;
    localparam int TMO_C  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] rom_data;
    logic [3:0] rom_addr;
    logic [3:0] leds;
    logic [4:0] round;
    logic       busy, win, fail;
    state_t     state;

    logic [3:0] seq_rom [16];
    int n_checks = 0;
    int n_errors = 0;

    genius_seq_ctrl #(
        .SHOW_CYCLES    (SHOW_C),
        .GAP_CYCLES     (GAP_C),
        .TIMEOUT_CYCLES (TMO_C)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .btn      (btn),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .leds     (leds),
        .round    (round),
        .busy     (busy),
        .win      (win),
        .fail     (fail),
        .state_o  (state)
    );

    assign rom_data = seq_rom[rom_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input state_t tgt, input int budget);
        int n = 0;
        while (state !== tgt && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("wait_%s", tgt.name()), 32'(state), 32'(tgt));
    endtask

    // Cycle-exact walk through the show phase; called on the first GAP cycle.
    task automatic show_round(input int r);
        for (int s = 0; s < r; s++) begin
            check($sformatf("r%0d_s%0d_gap1", r, s), 32'(state), 32'(ST_GAP));
            check($sformatf("r%0d_s%0d_gap_leds", r, s), 32'(leds), 32'd0);
            tick();
            check($sformatf("r%0d_s%0d_gap2", r, s), 32'(state), 32'(ST_GAP));
            tick();
            check($sformatf("r%0d_s%0d_show1", r, s), 32'(state), 32'(ST_SHOW));
            check($sformatf("r%0d_s%0d_show_leds", r, s), 32'(leds), 32'(seq_rom[s]));
            check($sformatf("r%0d_s%0d_addr", r, s), 32'(rom_addr), 32'(s));
            repeat (SHOW_C - 1) tick();
            check($sformatf("r%0d_s%0d_show4", r, s), 32'(state), 32'(ST_SHOW));
            tick();
        end
        check($sformatf("r%0d_input", r), 32'(state), 32'(ST_INPUT));
        check($sformatf("r%0d_busy", r), 32'(busy), 32'd1);
    endtask

    task automatic play_round(input int r);
        wait_state(ST_INPUT, 500);
        for (int s = 0; s < r; s++) begin
            btn = seq_rom[s];
            tick();
            check($sformatf("r%0d_s%0d_release", r, s), 32'(state), 32'(ST_RELEASE));
            btn = 4'b0000;
            tick();
            if (s < r - 1) check($sformatf("r%0d_s%0d_next", r, s), 32'(state), 32'(ST_INPUT));
        end
        if (r < 16) begin
            check($sformatf("r%0d_gap", r), 32'(state), 32'(ST_GAP));
            check($sformatf("r%0d_round", r), 32'(round), 32'(r + 1));
        end else begin
            check("r16_win_state", 32'(state), 32'(ST_WIN));
        end
    endtask

    initial begin
        seq_rom[0]  = 4'b0001; seq_rom[1]  = 4'b1000; seq_rom[2]  = 4'b0100; seq_rom[3]  = 4'b0010;
        seq_rom[4]  = 4'b0001; seq_rom[5]  = 4'b0100; seq_rom[6]  = 4'b1000; seq_rom[7]  = 4'b0010;
        seq_rom[8]  = 4'b0100; seq_rom[9]  = 4'b0001; seq_rom[10] = 4'b0010; seq_rom[11] = 4'b1000;
        seq_rom[12] = 4'b0001; seq_rom[13] = 4'b0010; seq_rom[14] = 4'b0100; seq_rom[15] = 4'b0010;

        // Reset values
        repeat (2) tick();
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_round", 32'(round), 32'd1);
        check("rst_flags", {29'd0, busy, win, fail}, 32'd0);
        rst_n = 1'b1;
        tick();

        // First round: timing of GAP and SHOW
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_round", 32'(round), 32'd1);
        show_round(1);

        // Correct press, release, second round show
        btn = 4'b0001;
        tick();
        check("r1_release", 32'(state), 32'(ST_RELEASE));
        check("r1_release_leds", 32'(leds), 32'b0001);
        btn = 4'b0000;
        tick();
        check("r1_to_gap", 32'(state), 32'(ST_GAP));
        check("r1_to_round2", 32'(round), 32'd2);
        show_round(2);

        // Wrong second press
        btn = 4'b0001; tick(); btn = 4'b0000; tick();
        check("r2_s0_input", 32'(state), 32'(ST_INPUT));
        btn = 4'b0100;
        tick();
        check("wrong_fail", 32'(fail), 32'd1);
        check("wrong_leds", 32'(leds), 32'd0);
        check("wrong_busy", 32'(busy), 32'd0);
        btn = 4'b0000;
        repeat (3) tick();
        check("fail_hold", 32'(state), 32'(ST_FAIL));

        // Full game; buttons held through INPUT entry are ignored
        start = 1'b1; tick(); start = 1'b0;
        check("restart_round", 32'(round), 32'd1);
        btn = 4'b1111;
        wait_state(ST_INPUT, 50);
        repeat (3) tick();
        check("held_ignored", 32'(state), 32'(ST_INPUT));
        check("held_leds", 32'(leds), 32'b1111);
        btn = 4'b0000;
        tick();
        play_round(1);
        start = 1'b1; tick(); start = 1'b0;
        check("busy_start_round", 32'(round), 32'd2);
        check("busy_start_state", 32'(state), 32'(ST_GAP));
        for (int r = 2; r <= 16; r++) play_round(r);
        check("win_flag", 32'(win), 32'd1);
        check("win_leds", 32'(leds), 32'b1111);
        check("win_busy", 32'(busy), 32'd0);
        check("win_round", 32'(round), 32'd16);
        start = 1'b1; tick(); start = 1'b0;
        check("win_restart_round", 32'(round), 32'd1);
        check("win_restart_state", 32'(state), 32'(ST_GAP));
        check("win_restart_flag", 32'(win), 32'd0);

        // Asynchronous reset during round 3 SHOW
        play_round(1);
        play_round(2);
        wait_state(ST_SHOW, 50);
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'(ST_IDLE));
        check("arst_addr", 32'(rom_addr), 32'd0);
        check("arst_leds", 32'(leds), 32'd0);
        check("arst_round", 32'(round), 32'd1);
        check("arst_flags", {29'd0, busy, win, fail}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Multi-hot press fails even when it contains the right colour
        start = 1'b1; tick(); start = 1'b0;
        wait_state(ST_INPUT, 50);
        btn = 4'b0011;
        tick();
        check("multihot_fail", 32'(fail), 32'd1);
        btn = 4'b0000;

        // Input timeout behaviour
        start = 1'b1; tick(); start = 1'b0;
        wait_state(ST_INPUT, 50);
`ifdef GENIUS_TIMEOUT_EN
        repeat (TMO_C - 1) tick();
        check("tmo_before", 32'(state), 32'(ST_INPUT));
        tick();
        check("tmo_fail", 32'(fail), 32'd1);
`else
        repeat (1000) tick();
        check("no_tmo_state", 32'(state), 32'(ST_INPUT));
        check("no_tmo_fail", 32'(fail), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
